// File: rtl/matrix_pkg.sv
// Shared constants and state encoding for the matrix loader and the
// downstream convolution stage.
package matrix_pkg;

    localparam int ROW_LIMIT   = 10;
    localparam int WINDOW_SIZE = 3;
    localparam int PIX_W       = 5;

    // LOAD: collecting elements; HOLD: presenting a complete frame.
    typedef enum logic [0:0] {
        LOAD = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/matrix_loader.sv
// matrix_loader: collects a ROW_LIMIT x ROW_LIMIT frame of PIX_W-bit elements
// arriving in raster order and presents it in bit-plane layout until the
// downstream stage acknowledges it.
// Build option: define MATRIX_LOADER_ZERO_FILL_EN to accept short frames
// (an early in_last completes the frame with the remaining elements left 0).
// Without it, an early in_last flags frame_err and restarts the frame.
module matrix_loader
    import matrix_pkg::*;
#(
    parameter int ROW_LIMIT = matrix_pkg::ROW_LIMIT,
    parameter int PIX_W     = matrix_pkg::PIX_W
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [PIX_W-1:0]                    in_data,
    input  logic                                in_last,
    output logic [PIX_W*ROW_LIMIT*ROW_LIMIT-1:0] out_matrix,
    output logic                                out_valid,
    input  logic                                out_ack,
    output logic                                frame_err
);

    localparam int ELEMS = ROW_LIMIT * ROW_LIMIT;
    localparam int CNT_W = $clog2(ELEMS);
    localparam int MAT_W = PIX_W * ELEMS;
    localparam int IDX_W = $clog2(MAT_W);
    localparam logic [CNT_W-1:0] LAST_K = CNT_W'(ELEMS - 1);

`ifdef MATRIX_LOADER_ZERO_FILL_EN
    localparam logic ZERO_FILL = 1'b1;
`else
    localparam logic ZERO_FILL = 1'b0;
`endif

    state_t             state_r;
    state_t             state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [MAT_W-1:0]   out_matrix_r;
    logic               frame_err_r;
    logic               in_ready_s;
    logic               out_valid_s;
    logic               accept_s;
    logic               last_k_s;
    logic               early_last_s;

    assign accept_s     = in_valid & in_ready_s;
    assign last_k_s     = (cnt_r == LAST_K);
    assign early_last_s = in_last & ~last_k_s;

    // State register; reset always returns to LOAD, dropping any frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= LOAD;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state: finish the frame on the last element (or an early last when
    // zero-fill is enabled); release the held frame on out_ack.
    always_comb begin
        state_s = state_r;
        case (state_r)
            LOAD: begin
                if (accept_s && (last_k_s || (ZERO_FILL && early_last_s))) begin
                    state_s = HOLD;
                end else begin
                    state_s = LOAD;
                end
            end
            HOLD: begin
                if (out_ack) begin
                    state_s = LOAD;
                end else begin
                    state_s = HOLD;
                end
            end
            default: state_s = LOAD;
        endcase
    end

    // Handshake decode from the state register; in_ready is masked by rst so
    // it is low during reset yet high in the very first cycle after release.
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        case (state_r)
            LOAD: begin
                in_ready_s  = ~rst;
                out_valid_s = 1'b0;
            end
            HOLD: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b1;
            end
            default: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b0;
            end
        endcase
    end

    // Frame storage, element counter and framing-error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r        <= '0;
            out_matrix_r <= '0;
            frame_err_r  <= 1'b0;
        end else begin
            frame_err_r <= 1'b0;
            if (state_r == HOLD) begin
                if (out_ack) begin
                    cnt_r        <= '0;
                    out_matrix_r <= '0;
                end
            end else if (accept_s) begin
                if (early_last_s && !ZERO_FILL) begin
                    // Short frame: throw it away and start over from k = 0.
                    cnt_r        <= '0;
                    out_matrix_r <= '0;
                    frame_err_r  <= 1'b1;
                end else begin
                    // Scatter the element's bits across the bit planes.
                    for (int b = 0; b < PIX_W; b++) begin
                        out_matrix_r[IDX_W'(b * ELEMS) + IDX_W'(cnt_r)] <= in_data[b];
                    end
                    cnt_r       <= cnt_r + CNT_W'(1);
                    // A full frame without in_last on its final element is
                    // still delivered, but flagged.
                    frame_err_r <= last_k_s & ~in_last;
                end
            end
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_s;
    assign out_matrix = out_matrix_r;
    assign frame_err  = frame_err_r;

endmodule

// File: tb/tb_matrix_loader.sv
// Self-checking bench for matrix_loader: table of frame scenarios plus
// hand-written hold and mid-frame reset sequences; expected frames flow
// through a scoreboard queue.
module tb_matrix_loader;

    localparam int RL    = 10;
    localparam int PW    = 5;
    localparam int N     = RL * RL;
    localparam int MW    = PW * N;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_data;
    logic          in_last;
    logic [MW-1:0] out_matrix;
    logic          out_valid;
    logic          out_ack;
    logic          frame_err;

    int tests = 0;
    int fails = 0;
    int err_pulses = 0;
    logic [MW-1:0] sb_q[$];

    typedef struct {
        int n;         // elements driven
        int last_at;   // index carrying in_last (-1: never)
        bit gaps;      // random in_valid gaps and out_ack noise
        bit exp_err;   // frame_err pulse expected right after the final element
        bit exp_hold;  // frame expected to be presented
    } vec_t;

    vec_t vecs[7];

    matrix_loader #(.ROW_LIMIT(RL), .PIX_W(PW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_matrix (out_matrix),
        .out_valid  (out_valid),
        .out_ack    (out_ack),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    // Count every cycle in which frame_err is high.
    always @(negedge clk) begin
        if (frame_err === 1'b1) err_pulses++;
    end

    task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive n elements (k%32, or 5'h1F on an early last) and build the expected frame.
    task automatic send_frame(input int n, input int last_at, input bit gaps,
                              output logic [MW-1:0] exp);
        logic [PW-1:0] d;
        bit acc;
        bit rdy;
        bit v;
        int guard;
        exp = '0;
        for (int k = 0; k < n; k++) begin
            d = (k == last_at && last_at < N - 1) ? 5'h1F : PW'(k % 32);
            acc = 1'b0;
            guard = 0;
            while (!acc) begin
                if (gaps && $urandom_range(0, 1) == 0) begin
                    in_valid = 1'b0;
                    in_data  = PW'($urandom);
                    in_last  = 1'($urandom);
                end else begin
                    in_valid = 1'b1;
                    in_data  = d;
                    in_last  = (k == last_at);
                end
                out_ack = gaps ? 1'($urandom) : 1'b0;
                rdy = in_ready;
                v   = in_valid;
                @(posedge clk); #1;
                acc = rdy && v;
                guard++;
                if (guard > 200) begin
                    check($sformatf("accept_timeout_k%0d", k), 512'(0), 512'(1));
                    break;
                end
            end
            for (int b = 0; b < PW; b++) exp[b * N + k] = d[b];
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        out_ack  = 1'b0;
    endtask

    task automatic run_vec(input string nm, input vec_t v);
        logic [MW-1:0] exp;
        logic [MW-1:0] got;
        int e0;
        e0 = err_pulses;
        send_frame(v.n, v.last_at, v.gaps, exp);
        check({nm, "_err"}, 512'(frame_err), 512'(v.exp_err));
        if (v.exp_hold) begin
            sb_q.push_back(exp);
            check({nm, "_valid"}, 512'(out_valid), 512'(1));
            check({nm, "_rdy_hold"}, 512'(in_ready), 512'(0));
            got = sb_q.pop_front();
            check({nm, "_matrix"}, 512'(out_matrix), 512'(got));
            out_ack = 1'b1;
            @(posedge clk); #1;
            out_ack = 1'b0;
            check({nm, "_rdy_ack"}, 512'(in_ready), 512'(1));
            check({nm, "_valid_ack"}, 512'(out_valid), 512'(0));
            check({nm, "_clr_ack"}, 512'(out_matrix), 512'(0));
        end else begin
            check({nm, "_valid_drop"}, 512'(out_valid), 512'(0));
            check({nm, "_rdy_drop"}, 512'(in_ready), 512'(1));
            check({nm, "_clr_drop"}, 512'(out_matrix), 512'(0));
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        check({nm, "_pulses"}, 512'(err_pulses - e0), 512'(v.exp_err));
    endtask

    task automatic hold_test();
        logic [MW-1:0] exp;
        send_frame(N, N - 1, 1'b0, exp);
        check("hold_valid", 512'(out_valid), 512'(1));
        check("hold_matrix", 512'(out_matrix), 512'(exp));
        for (int c = 0; c < 20; c++) begin
            in_valid = 1'b1;
            in_data  = PW'($urandom);
            in_last  = 1'($urandom);
            @(posedge clk); #1;
            check($sformatf("hold_rdy_c%0d", c), 512'(in_ready), 512'(0));
            check($sformatf("hold_stable_c%0d", c), 512'(out_matrix), 512'(exp));
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        out_ack  = 1'b1;
        @(posedge clk); #1;
        out_ack = 1'b0;
        check("hold_rdy_after_ack", 512'(in_ready), 512'(1));
        check("hold_clr_after_ack", 512'(out_matrix), 512'(0));
    endtask

    task automatic reset_mid_test();
        logic [MW-1:0] exp;
        vec_t v;
        int e0;
        e0 = err_pulses;
        send_frame(57, -1, 1'b0, exp);
        rst      = 1'b1;
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            in_data = PW'($urandom);
            @(posedge clk); #1;
            check($sformatf("rstmid_valid_c%0d", c), 512'(out_valid), 512'(0));
            check($sformatf("rstmid_rdy_c%0d", c), 512'(in_ready), 512'(0));
            check($sformatf("rstmid_mat_c%0d", c), 512'(out_matrix), 512'(0));
            check($sformatf("rstmid_err_c%0d", c), 512'(frame_err), 512'(0));
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rstmid_rdy_release", 512'(in_ready), 512'(1));
        check("rstmid_pulses", 512'(err_pulses - e0), 512'(0));
        v = '{n: N, last_at: N - 1, gaps: 1'b0, exp_err: 1'b0, exp_hold: 1'b1};
        run_vec("rstmid_reload", v);
    endtask

    initial begin
        vecs[0] = '{n: N,  last_at: N - 1, gaps: 1'b0, exp_err: 1'b0, exp_hold: 1'b1};
        vecs[1] = '{n: N,  last_at: -1,    gaps: 1'b0, exp_err: 1'b1, exp_hold: 1'b1};
`ifdef MATRIX_LOADER_ZERO_FILL_EN
        vecs[2] = '{n: 42, last_at: 41,    gaps: 1'b0, exp_err: 1'b0, exp_hold: 1'b1};
`else
        vecs[2] = '{n: 42, last_at: 41,    gaps: 1'b0, exp_err: 1'b1, exp_hold: 1'b0};
`endif
        vecs[3] = '{n: N,  last_at: N - 1, gaps: 1'b0, exp_err: 1'b0, exp_hold: 1'b1};
        vecs[4] = '{n: N,  last_at: N - 1, gaps: 1'b1, exp_err: 1'b0, exp_hold: 1'b1};
        vecs[5] = '{n: N,  last_at: N - 1, gaps: 1'b1, exp_err: 1'b0, exp_hold: 1'b1};
        vecs[6] = '{n: N,  last_at: N - 1, gaps: 1'b1, exp_err: 1'b0, exp_hold: 1'b1};

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        out_ack  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", 512'(out_valid), 512'(0));
        check("reset_rdy", 512'(in_ready), 512'(0));
        check("reset_matrix", 512'(out_matrix), 512'(0));
        check("reset_err", 512'(frame_err), 512'(0));
        rst = 1'b0;
        #1;
        check("rdy_after_reset", 512'(in_ready), 512'(1));

        for (int i = 0; i < 7; i++) run_vec($sformatf("v%0d", i), vecs[i]);
        hold_test();
        reset_mid_test();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/matrix_loader.md
MATRIX_LOADER -- requirements
Module: matrix_loader

Interface
REQ-001 SHALL have parameter ROW_LIMIT, default 10: matrix is ROW_LIMIT x ROW_LIMIT elements.
REQ-002 SHALL have parameter PIX_W, default 5: bits per element.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  upstream element valid.
REQ-006 SHALL have port in_ready  output  1  loader can accept an element.
REQ-007 SHALL have port in_data  input  PIX_W  element value, raster order (row-major, col 0 first).
REQ-008 SHALL have port in_last  input  1  marks the final element of a frame.
REQ-009 SHALL have port out_matrix  output  PIX_W*ROW_LIMIT*ROW_LIMIT  assembled frame in bit-plane layout.
REQ-010 SHALL have port out_valid  output  1  out_matrix holds a complete frame.
REQ-011 SHALL have port out_ack  input  1  downstream convolution stage has consumed the frame.
REQ-012 SHALL have port frame_err  output  1  one-cycle pulse on a framing violation.

Function
REQ-013 SHALL accept an element when in_valid and in_ready are both 1 in the same cycle.
REQ-014 SHALL store bit b of element k, where k = row*ROW_LIMIT + col, at out_matrix[b*ROW_LIMIT*ROW_LIMIT + k].
REQ-015 SHALL keep an element counter of $clog2(ROW_LIMIT*ROW_LIMIT) bits that holds k of the next element and increments once per accepted element.
REQ-016 SHALL implement two states: LOAD (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-017 LOAD -> HOLD SHALL occur when the element with k = ROW_LIMIT*ROW_LIMIT-1 is accepted; out_valid rises on the next cycle, i.e. latency 1 cycle.
REQ-018 That final element accepted with in_last=0 SHALL still complete the frame, and SHALL pulse frame_err for one cycle.
REQ-019 HOLD SHALL keep out_matrix stable and keep in_ready at 0 until out_ack=1.
REQ-020 On out_ack=1 in HOLD, the block SHALL go to LOAD on the next cycle, clear out_matrix to 0 and set the counter to 0.
REQ-021 out_ack SHALL be ignored in LOAD.
REQ-022 in_data and in_last SHALL be ignored when in_valid=0, and in every cycle spent in HOLD.
REQ-023 An in_last accepted with k < ROW_LIMIT*ROW_LIMIT-1 SHALL be handled as defined under Configuration.
REQ-024 frame_err SHALL be 0 in every cycle other than the pulses defined in REQ-018 and REQ-023.

Reset
REQ-025 While rst=1, the block SHALL set state to LOAD, counter to 0, out_matrix to 0, out_valid to 0, frame_err to 0 and in_ready to 0.
REQ-026 After rst falls, in_ready SHALL be 1 in the first cycle.
REQ-027 A reset during LOAD or HOLD SHALL discard the partial or held frame, with no frame_err pulse.

Configuration
REQ-028 Macro MATRIX_LOADER_ZERO_FILL_EN defined: an early in_last SHALL store that element, leave the remaining elements 0, go to HOLD, and raise no frame_err.
REQ-029 Macro MATRIX_LOADER_ZERO_FILL_EN undefined: an early in_last SHALL pulse frame_err, discard the partial frame (out_matrix cleared, counter 0) and remain in LOAD.

Structure
REQ-030 Package matrix_pkg SHALL hold the constants ROW_LIMIT=10, WINDOW_SIZE=3 and PIX_W=5, plus the state enum typedef (LOAD, HOLD), shared with the convolution stage.
REQ-031 The block SHALL be a single module with no sub-modules; the counter and FSM are inline.

Verification
REQ-032 Reset, then 100 elements with in_data=k%32, in_last only on k=99 -> out_valid=1 one cycle after element 99, every plane bit matches, frame_err stays 0.
REQ-033 Hold out_ack=0 for 20 cycles after frame complete while driving in_valid=1 -> in_ready=0, out_matrix unchanged; then out_ack=1 -> next cycle in_ready=1, out_matrix=0.
REQ-034 100 elements with in_last=0 throughout -> frame completes, one frame_err pulse in the cycle after element 99.
REQ-035 in_last on element 41 with value 5'h1F -> defined: HOLD entered, elements 0..41 loaded, elements 42..99 = 0; undefined: one frame_err pulse, LOAD kept, counter 0.
REQ-036 Assert rst at element 57 of a frame -> all outputs 0 during reset, in_ready=1 after release, next full frame loads correctly from k=0.
REQ-037 Random in_valid gaps (about 50% duty) over 3 back-to-back frames with immediate out_ack -> all 3 frames correct, no element lost or duplicated.
